// File: rtl/axi_rd_pkg.sv
// Shared encodings, FSM state type and address-step helper for the AXI read front end.
package axi_rd_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] REG_FIFO = 2'd0;
  localparam logic [1:0] REG_IRAM = 2'd1;
  localparam logic [1:0] REG_WRAM = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} rd_state_e;

  typedef logic [31:0] addr_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Computed on a wide address; the caller truncates to its own width, which
  // gives INCR its modulo-2^ADDR_W wrap for free.
  function automatic addr_t next_addr(input logic [1:0] burst, input logic [2:0] size,
                                      input logic [7:0] len, input addr_t addr);
    addr_t step;
    addr_t mask;
    step = addr_t'(1) << size;
    mask = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + step) & mask);
      default:     next_addr = addr + step;
    endcase
  endfunction

endpackage

// File: rtl/axi_read_inft_if.sv
// AXI4 read address / read data channel bundle.
interface axi_read_inft_if #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) ();
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [LEN_W-1:0]  ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic [3:0]        ARREGION;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARREGION, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARREGION, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_rd_skid.sv
// Two-entry R-channel buffer; an empty buffer passes the incoming beat straight through.
module axi_rd_skid
  import axi_rd_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic [1:0]        push_resp,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        out_resp,
  output logic [1:0]        count
);

  logic [1:0][DATA_W-1:0] data_q, data_d;
  logic [1:0]             last_q, last_d;
  logic [1:0][1:0]        resp_q, resp_d;
  logic                   wr_q, wr_d, rd_q, rd_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   empty, pop_ok;

  assign empty     = (cnt_q == 2'd0);
  assign out_valid = !rst && (!empty || push);
  assign pop_ok    = pop && out_valid;
  assign count     = cnt_q;

  // Every push is written even when it bypasses, so pointers stay in lockstep.
  always_comb begin
    data_d = data_q;
    last_d = last_q;
    resp_d = resp_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    if (push) begin
      data_d[wr_q] = push_data;
      last_d[wr_q] = push_last;
      resp_d[wr_q] = push_resp;
      wr_d         = !wr_q;
    end
    if (pop_ok) rd_d = !rd_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop_ok};
  end

  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    out_resp = RESP_OKAY;
    if (out_valid) begin
      if (empty) begin
        out_data = push_data;
        out_last = push_last;
        out_resp = push_resp;
      end else begin
        out_data = data_q[rd_q];
        out_last = last_q[rd_q];
        out_resp = resp_q[rd_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      last_q <= '0;
      resp_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      data_q <= data_d;
      last_q <= last_d;
      resp_q <= resp_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_read_inft.sv
// AXI4 read slave: one AR burst at a time -> RAM read strobes -> R beats via skid buffer.
// Optional burst error checking (SLVERR beats, no RAM reads) under `AXI_RD_ERR_CHK_EN.
module axi_read_inft
  import axi_rd_pkg::*;
#(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  axi_read_inft_if.slave     axi,
  output logic               axi_rd_vld,
  output logic [ADDR_W-1:0]  axi_rd_addr,
  output logic [1:0]         axi_rd_region,
  input  logic [DATA_W-1:0]  ram_rd_data
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W/8));

  rd_state_e         state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d, region_q, region_d;
  logic              err_q, err_d;
  logic              pipe_vld_q, pipe_vld_d, pipe_last_q, pipe_last_d, pipe_err_q, pipe_err_d;
  logic              issue;
  logic [1:0]        in_flight, skid_cnt;
  logic              r_valid, r_last;
  logic              unused_region_hi;

  assign unused_region_hi = |axi.ARREGION[3:2];
  assign in_flight        = {1'b0, pipe_vld_q} + skid_cnt;

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    size_d   = size_q;
    burst_d  = burst_q;
    region_d = region_q;
    err_d    = err_q;
    issue    = 1'b0;
    case (state_q)
      ST_IDLE: if (axi.ARVALID) begin
        id_d     = axi.ARID;
        addr_d   = axi.ARADDR;
        len_d    = axi.ARLEN;
        cnt_d    = axi.ARLEN;
        size_d   = (axi.ARSIZE > MAX_SIZE) ? MAX_SIZE : axi.ARSIZE;
        region_d = axi.ARREGION[1:0];
        burst_d  = axi.ARBURST;
        // Reserved burst code and malformed WRAP degrade to INCR addressing.
        if (axi.ARBURST == 2'b11 ||
            (axi.ARBURST == BURST_WRAP && !wrap_len_ok(8'(axi.ARLEN))))
          burst_d = BURST_INCR;
`ifdef AXI_RD_ERR_CHK_EN
        err_d = (axi.ARREGION[1:0] == 2'd3) || (axi.ARBURST == 2'b11) ||
                (axi.ARBURST == BURST_WRAP && !wrap_len_ok(8'(axi.ARLEN)));
`else
        err_d = 1'b0;
`endif
        state_d = ST_ISSUE;
      end
      // Gate on reads in flight plus buffered beats so the skid can never overflow.
      ST_ISSUE: if (!rst && in_flight < 2'd2) begin
        issue  = 1'b1;
        addr_d = ADDR_W'(next_addr(burst_q, size_q, 8'(len_q), addr_t'(addr_q)));
        cnt_d  = cnt_q - LEN_W'(1);
        if (cnt_q == '0) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (r_valid && axi.RREADY && r_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    pipe_vld_d  = issue;
    pipe_last_d = issue && (cnt_q == '0);
    pipe_err_d  = issue && err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      region_q    <= '0;
      err_q       <= 1'b0;
      pipe_vld_q  <= 1'b0;
      pipe_last_q <= 1'b0;
      pipe_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      region_q    <= region_d;
      err_q       <= err_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      pipe_err_q  <= pipe_err_d;
    end
  end

  assign axi.ARREADY   = (state_q == ST_IDLE) && !rst;
  assign axi.RID       = id_q;
  assign axi_rd_vld    = issue && !err_q;
  assign axi_rd_addr   = addr_q;
  assign axi_rd_region = region_q;

  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;

  axi_rd_skid #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_vld_q),
    .push_data (pipe_err_q ? '0 : ram_rd_data),
    .push_last (pipe_last_q),
    .push_resp (pipe_err_q ? RESP_SLVERR : RESP_OKAY),
    .pop       (axi.RREADY),
    .out_valid (r_valid),
    .out_data  (r_data),
    .out_last  (r_last),
    .out_resp  (r_resp),
    .count     (skid_cnt)
  );

  assign axi.RVALID = r_valid;
  assign axi.RDATA  = r_data;
  assign axi.RLAST  = r_last;
  assign axi.RRESP  = r_resp;

endmodule
